// File: rtl/lens_remap_bilinear_sampler_pkg.sv
// Shared RGB565 field layout, pipeline latency and saturation helpers for the
// lens-remap bilinear sampler.
package lens_remap_bilinear_sampler_pkg;

    localparam int RGB_B_LSB = 0;
    localparam int RGB_B_W   = 5;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_G_W   = 6;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_R_W   = 5;

    typedef enum logic [1:0] {
        CH_B = 2'd0,
        CH_G = 2'd1,
        CH_R = 2'd2
    } rgb_ch_e;

    // Per-pixel flags that ride alongside the memory read
    typedef struct packed {
        logic issued;
        logic edge_x;
        logic oob;
    } side_flags_t;

    function automatic int rgb_lsb(input int ch);
        case (rgb_ch_e'(ch))
            CH_B:    return RGB_B_LSB;
            CH_G:    return RGB_G_LSB;
            default: return RGB_R_LSB;
        endcase
    endfunction

    function automatic int rgb_width(input int ch);
        case (rgb_ch_e'(ch))
            CH_B:    return RGB_B_W;
            CH_G:    return RGB_G_W;
            default: return RGB_R_W;
        endcase
    endfunction

    function automatic int default_latency(input int mem_lat);
        return mem_lat + 3;
    endfunction

    function automatic logic [31:0] clamp_ch(input logic [31:0] v, input int ch_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ch_w) - 32'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/lens_remap_bilinear_sampler_if.sv
// Coordinate/video input, frame-buffer read ports and corrected pixel output.
interface lens_remap_bilinear_sampler_if #(
    parameter int ADDR_W = 20
);
    logic [15:0]       in_src_x;
    logic [15:0]       in_src_y;
    logic              in_valid;
    logic              in_de;
    logic              in_hs;
    logic              in_vs;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [31:0]       rd_data0;
    logic [31:0]       rd_data1;
    logic [15:0]       out_rgb;
    logic              out_de;
    logic              out_hs;
    logic              out_vs;

    modport slave (
        input  in_src_x, in_src_y, in_valid, in_de, in_hs, in_vs, rd_data0, rd_data1,
        output rd_en, rd_addr0, rd_addr1, out_rgb, out_de, out_hs, out_vs
    );

    modport master (
        output in_src_x, in_src_y, in_valid, in_de, in_hs, in_vs, rd_data0, rd_data1,
        input  rd_en, rd_addr0, rd_addr1, out_rgb, out_de, out_hs, out_vs
    );
endinterface

// File: rtl/lens_remap_bilinear_sampler_bilinear_channel_blend.sv
// One colour channel: registered weighted products, then round-half-up sum and clamp.
module bilinear_channel_blend
    import lens_remap_bilinear_sampler_pkg::*;
#(
    parameter int CH_W      = 5,
    parameter int FRAC_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH_W-1:0]        p00,
    input  logic [CH_W-1:0]        p01,
    input  logic [CH_W-1:0]        p10,
    input  logic [CH_W-1:0]        p11,
    input  logic [2*FRAC_BITS:0]   w00,
    input  logic [2*FRAC_BITS:0]   w01,
    input  logic [2*FRAC_BITS:0]   w10,
    input  logic [2*FRAC_BITS:0]   w11,
    output logic [CH_W-1:0]        ch
);
    localparam int PROD_W = CH_W + 2*FRAC_BITS + 2;
    localparam int SUM_W  = PROD_W + 2;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (2*FRAC_BITS - 1);

    logic [CH_W-1:0]      p [4];
    logic [2*FRAC_BITS:0] w [4];
    logic [PROD_W-1:0]    prod_reg [4];
    logic [SUM_W-1:0]     sum_next;

    assign p[0] = p00;
    assign p[1] = p01;
    assign p[2] = p10;
    assign p[3] = p11;
    assign w[0] = w00;
    assign w[1] = w01;
    assign w[2] = w10;
    assign w[3] = w11;

    for (genvar gi = 0; gi < 4; gi++) begin : g_prod
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) prod_reg[gi] <= '0;
            else        prod_reg[gi] <= PROD_W'(p[gi]) * PROD_W'(w[gi]);
        end
    end

    assign sum_next = SUM_W'(prod_reg[0]) + SUM_W'(prod_reg[1])
                    + SUM_W'(prod_reg[2]) + SUM_W'(prod_reg[3]) + HALF;
    assign ch = CH_W'(clamp_ch(32'(sum_next >> (2*FRAC_BITS)), CH_W));

endmodule

// File: rtl/lens_remap_bilinear_sampler.sv
// Fetches the 2x2 RGB565 neighbourhood of a fixed-point source coordinate and
// emits the bilinear blend with DE/HS/VS delayed by the same pipeline latency.
module lens_remap_bilinear_sampler
    import lens_remap_bilinear_sampler_pkg::*;
#(
    parameter int H_RES     = 1280,
    parameter int V_RES     = 720,
    parameter int FRAC_BITS = 4,
    parameter int ADDR_W    = 20,
    parameter int MEM_LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lens_remap_bilinear_sampler_if.slave bus
);
    localparam int LAT   = default_latency(MEM_LAT);
    localparam int INT_W = 16 - FRAC_BITS;
    localparam int W_W   = 2*FRAC_BITS + 1;
    localparam logic [FRAC_BITS:0] N_ONE = (FRAC_BITS+1)'(1 << FRAC_BITS);

    logic [INT_W-1:0]     x0, y0;
    logic [FRAC_BITS-1:0] fx_a, fy_a;
    logic [31:0]          y1_a;
    logic                 oob_a, edge_a, issue_a;

    assign x0      = bus.in_src_x[15:FRAC_BITS];
    assign y0      = bus.in_src_y[15:FRAC_BITS];
    assign fx_a    = bus.in_src_x[FRAC_BITS-1:0];
    assign fy_a    = bus.in_src_y[FRAC_BITS-1:0];
    assign oob_a   = (32'(x0) >= 32'(H_RES)) || (32'(y0) >= 32'(V_RES));
    assign edge_a  = (32'(x0) == 32'(H_RES - 1));
    assign y1_a    = (32'(y0) >= 32'(V_RES - 1)) ? 32'(V_RES - 1) : 32'(y0) + 32'd1;
    assign issue_a = bus.in_valid & bus.in_de & ~oob_a;

    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr0_reg, rd_addr1_reg;
    logic [FRAC_BITS-1:0] fx_pipe [0:MEM_LAT];
    logic [FRAC_BITS-1:0] fy_pipe [0:MEM_LAT];
    side_flags_t          flag_pipe [0:MEM_LAT];

    // Addresses hold while idle so the memory bus does not toggle in blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_reg    <= 1'b0;
            rd_addr0_reg <= '0;
            rd_addr1_reg <= '0;
            fx_pipe[0]   <= '0;
            fy_pipe[0]   <= '0;
            flag_pipe[0] <= '0;
        end else begin
            rd_en_reg    <= issue_a;
            if (issue_a) begin
                rd_addr0_reg <= ADDR_W'(32'(y0) * 32'(H_RES) + 32'(x0));
                rd_addr1_reg <= ADDR_W'(y1_a * 32'(H_RES) + 32'(x0));
            end
            fx_pipe[0]   <= fx_a;
            fy_pipe[0]   <= fy_a;
            flag_pipe[0] <= '{issued: issue_a, edge_x: edge_a, oob: oob_a};
        end
    end

    for (genvar gi = 1; gi <= MEM_LAT; gi++) begin : g_side
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fx_pipe[gi]   <= '0;
                fy_pipe[gi]   <= '0;
                flag_pipe[gi] <= '0;
            end else begin
                fx_pipe[gi]   <= fx_pipe[gi-1];
                fy_pipe[gi]   <= fy_pipe[gi-1];
                flag_pipe[gi] <= flag_pipe[gi-1];
            end
        end
    end

    assign bus.rd_en    = rd_en_reg;
    assign bus.rd_addr0 = rd_addr0_reg;
    assign bus.rd_addr1 = rd_addr1_reg;

    // Data return: at the right column edge addr+1 wraps to the next row, so reuse x0
    side_flags_t        flags_b;
    logic [15:0]        p00, p01, p10, p11;
    logic [FRAC_BITS:0] nfx, nfy, fx_b, fy_b;
    logic [W_W-1:0]     w00, w01, w10, w11;

    assign flags_b = flag_pipe[MEM_LAT];
    assign p00  = flags_b.issued ? bus.rd_data0[15:0] : 16'h0000;
    assign p10  = flags_b.issued ? bus.rd_data1[15:0] : 16'h0000;
    assign p01  = !flags_b.issued ? 16'h0000 : (flags_b.edge_x ? bus.rd_data0[15:0] : bus.rd_data0[31:16]);
    assign p11  = !flags_b.issued ? 16'h0000 : (flags_b.edge_x ? bus.rd_data1[15:0] : bus.rd_data1[31:16]);
    assign fx_b = {1'b0, fx_pipe[MEM_LAT]};
    assign fy_b = {1'b0, fy_pipe[MEM_LAT]};
    assign nfx  = N_ONE - fx_b;
    assign nfy  = N_ONE - fy_b;
    assign w00  = W_W'(nfx) * W_W'(nfy);
    assign w01  = W_W'(fx_b) * W_W'(nfy);
    assign w10  = W_W'(nfx) * W_W'(fy_b);
    assign w11  = W_W'(fx_b) * W_W'(fy_b);

    logic [15:0] blend_rgb;
    logic        mask_c_reg;
    logic [15:0] out_rgb_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam int CW  = rgb_width(gi);
        localparam int LSB = rgb_lsb(gi);
        bilinear_channel_blend #(.CH_W(CW), .FRAC_BITS(FRAC_BITS)) u_blend (
            .clk   (clk),
            .rst_n (rst_n),
            .p00   (p00[LSB +: CW]),
            .p01   (p01[LSB +: CW]),
            .p10   (p10[LSB +: CW]),
            .p11   (p11[LSB +: CW]),
            .w00   (w00),
            .w01   (w01),
            .w10   (w10),
            .w11   (w11),
            .ch    (blend_rgb[LSB +: CW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_c_reg  <= 1'b0;
            out_rgb_reg <= 16'h0000;
        end else begin
            mask_c_reg  <= flags_b.issued & ~flags_b.oob;
            out_rgb_reg <= mask_c_reg ? blend_rgb : 16'h0000;
        end
    end

    logic [2:0] sync_pipe [0:LAT-1];

    for (genvar gi = 0; gi < LAT; gi++) begin : g_sync
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       sync_pipe[gi] <= 3'b000;
            else if (gi == 0) sync_pipe[gi] <= {bus.in_de, bus.in_hs, bus.in_vs};
            else              sync_pipe[gi] <= sync_pipe[(gi == 0) ? 0 : gi-1];
        end
    end

    assign bus.out_rgb = out_rgb_reg;
    assign bus.out_de  = sync_pipe[LAT-1][2];
    assign bus.out_hs  = sync_pipe[LAT-1][1];
    assign bus.out_vs  = sync_pipe[LAT-1][0];

endmodule
